// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared opcodes and saturation limits for the pipelined adder
package add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Clamp value in the low w bits: most negative when neg, else most positive.
  function automatic logic [63:0] sat_limit(input int w, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (w - 1);
    return neg ? msb : msb - 64'd1;
  endfunction

endpackage

// File: rtl/add_seg.sv
// rtl/add_seg.sv - one registered carry segment of the adder pipeline
module add_seg
  import add_pkg::*;
#(
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          ctop
);

  logic [SW:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ctop <= 1'b0;
    end else if (en) begin
      sum  <= full[SW-1:0];
      cout <= full[SW];
      // carry into the top bit, recovered from that bit's sum
      ctop <= full[SW-1] ^ a[SW-1] ^ b[SW-1];
    end
  end

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - segmented-carry pipelined signed add/sub with saturation and valid/ready
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SEGS  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int SW   = WIDTH / SEGS;
  localparam int LAST = SEGS - 1;

  if (WIDTH % SEGS != 0) begin : g_bad_split
    $error("add_pipe: WIDTH must be a multiple of SEGS");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] a_q   [SEGS];
  logic [WIDTH-1:0] b_q   [SEGS];
  logic [WIDTH-1:0] lo_q  [SEGS];
  logic             v_q   [SEGS];
  logic             sat_q [SEGS];
  logic [SW-1:0]    s_seg [SEGS];
  logic             c_seg [SEGS];
  logic             ct_seg[SEGS];
  logic [WIDTH-1:0] raw;
  logic             unused_bits;

  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  // subtraction folds into addition: a + ~b + !cin
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c_eff = (op == OP_SUB) ? ~cin : cin;

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic          sc;
    if (k == 0) begin : g_head
      assign sa = a[SW-1:0];
      assign sb = b_eff[SW-1:0];
      assign sc = c_eff;
    end else begin : g_tail
      assign sa = a_q[k-1][k*SW +: SW];
      assign sb = b_q[k-1][k*SW +: SW];
      assign sc = c_seg[k-1];
    end
    add_seg #(.SW(SW)) u_seg (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .a    (sa),
      .b    (sb),
      .cin  (sc),
      .sum  (s_seg[k]),
      .cout (c_seg[k]),
      .ctop (ct_seg[k])
    );
  end

  // operands ride ahead of their slice; finished low slices ride behind
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SEGS; k++) begin
        v_q[k]   <= 1'b0;
        sat_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        lo_q[k]  <= '0;
      end
    end else if (adv) begin
      v_q[0]   <= in_valid;
      sat_q[0] <= sat;
      a_q[0]   <= a;
      b_q[0]   <= b_eff;
      lo_q[0]  <= '0;
      for (int k = 1; k < SEGS; k++) begin
        v_q[k]   <= v_q[k-1];
        sat_q[k] <= sat_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        lo_q[k]  <= lo_q[k-1] | (WIDTH'(s_seg[k-1]) << ((k - 1) * SW));
      end
    end
  end

  assign raw       = lo_q[LAST] | (WIDTH'(s_seg[LAST]) << (LAST * SW));
  assign out_valid = v_q[LAST];
  assign overflow  = ct_seg[LAST] ^ c_seg[LAST];

  // on overflow the wrapped sign is the inverse of the true sign
  always_comb begin
    sum = raw;
    if (sat_q[LAST] && overflow) begin
      sum = WIDTH'(sat_limit(WIDTH, !raw[WIDTH-1]));
    end
  end

  assign unused_bits = ^{a_q[LAST], b_q[LAST]};

endmodule
